// File: rtl/noc_pkg.sv
// noc_pkg: flit format, flit/port/arbiter enums and flit decode helpers shared by the mesh NoC.
package noc_pkg;
    localparam int FLIT_W    = 17;
    localparam int NUM_NODES = 16;
    localparam int VALID_BIT = 16;
    localparam int TYPE_MSB  = 15;
    localparam int TYPE_LSB  = 14;
    localparam int PAYLOAD_W = 14;
    localparam int NODE_W    = 4;
    localparam int DEST_LSB  = 0;
    localparam int SRC_LSB   = 4;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        N = 3'd0,
        E = 3'd1,
        S = 3'd2,
        W = 3'd3,
        L = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        IDLE,
        LOCKED,
        STALL
    } arb_state_e;

    function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] f);
        return flit_type_e'(f[TYPE_MSB:TYPE_LSB]);
    endfunction

    // HEAD and SINGLE share type bit 0, so one bit separates packet starts from continuations
    function automatic logic is_start(input logic [FLIT_W-1:0] f);
        return f[VALID_BIT] && f[TYPE_LSB];
    endfunction

    function automatic logic is_cont(input logic [FLIT_W-1:0] f);
        return f[VALID_BIT] && !f[TYPE_LSB];
    endfunction
endpackage

// File: rtl/noc_rr_pick.sv
// noc_rr_pick: combinational round-robin picker, first requester at or after ptr with wrap.
module noc_rr_pick #(
    parameter int NUM_IN = 5,
    localparam int PTR_W = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_IN-1:0] gnt,
    output logic [PTR_W-1:0]  idx,
    output logic              found
);
    // Scanning from the farthest offset down lets the nearest requester win last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_IN]) begin
                idx = PTR_W'((int'(ptr) + i) % NUM_IN);
                gnt = NUM_IN'(1) << ((int'(ptr) + i) % NUM_IN);
            end
        end
    end
    assign found = |req;
endmodule

// File: rtl/noc_out_port_arbiter.sv
// noc_out_port_arbiter: wormhole round-robin arbiter for one mesh router output port.
// Grants on HEAD/SINGLE, holds the owner until TAIL, and stalls while downstream is full.
module noc_out_port_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*FLIT_W-1:0] in_flit_i,
    output logic [NUM_IN-1:0]        in_pop_o,
    input  logic                     out_full_i,
    output logic [FLIT_W-1:0]        out_flit_o,
    output logic [NUM_IN-1:0]        grant_o,
    output logic                     locked_o,
    output logic                     err_o
);
    localparam int PTR_W = $clog2(NUM_IN);

    arb_state_e        state;
    logic [PTR_W-1:0]  rr_ptr, owner, pick_idx;
    logic [NUM_IN-1:0] req, bad, pick_gnt;
    logic [FLIT_W-1:0] flit [NUM_IN];
    logic [FLIT_W-1:0] own_flit, sel_flit;
    logic              found;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_IN - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            flit[k] = in_flit_i[k*FLIT_W +: FLIT_W];
            req[k]  = is_start(flit[k]);
            bad[k]  = is_cont(flit[k]);
        end
    end

    noc_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (found)
    );

    assign own_flit = flit[owner];
    assign sel_flit = (state == IDLE) ? flit[pick_idx] : own_flit;
    // grant_o already holds the owner one-hot, so it doubles as the locked-mode pop strobe
    assign in_pop_o = (rst || out_full_i) ? '0 :
                      (state == IDLE && found) ? pick_gnt :
                      (state == LOCKED && is_cont(own_flit)) ? grant_o : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            out_flit_o <= '0;
            grant_o    <= '0;
            locked_o   <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            out_flit_o <= |in_pop_o ? sel_flit : '0;
            if (!out_full_i && state == IDLE && |bad)
                err_o <= 1'b1;
            if (!out_full_i && state == LOCKED && is_start(own_flit)) begin
                err_o <= 1'b1;
                state <= STALL;
            end
            if (|in_pop_o && state == IDLE && flit_type(sel_flit) == SINGLE)
                rr_ptr <= next_ptr(pick_idx);
            if (|in_pop_o && state == IDLE && flit_type(sel_flit) == HEAD) begin
                state    <= LOCKED;
                owner    <= pick_idx;
                grant_o  <= pick_gnt;
                locked_o <= 1'b1;
            end
            if (|in_pop_o && state == LOCKED && flit_type(sel_flit) == TAIL) begin
                state    <= IDLE;
                grant_o  <= '0;
                locked_o <= 1'b0;
                rr_ptr   <= next_ptr(owner);
            end
        end
    end
endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// tb_noc_out_port_arbiter: directed and randomized checks against a packet-queue model of the arbiter.
module tb_noc_out_port_arbiter;
    import noc_pkg::*;

    logic                  clk = 1'b0, rst = 1'b1, full = 1'b0;
    logic [5*FLIT_W-1:0]   in_flit = '0;
    logic [4:0]            pop, grant, hold = '0;
    logic [FLIT_W-1:0]     out_flit;
    logic                  locked, err;

    noc_out_port_arbiter #(.NUM_IN(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_flit_i  (in_flit),
        .in_pop_o   (pop),
        .out_full_i (full),
        .out_flit_o (out_flit),
        .grant_o    (grant),
        .locked_o   (locked),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    logic [16:0] q [5][$];
    int          m_mode = 0, m_owner = 0, m_ptr = 0;
    logic        m_err = 1'b0;
    logic [16:0] m_out = '0;
    // {pop[28:24], out_flit[23:7], grant[6:2], locked[1], err[0]}
    logic [28:0] obs_v, exp_v;
    int          vectors = 0, miscompares = 0;

    function automatic logic [16:0] hdr_flit(input logic [1:0] t, input int src, input int dst);
        return {1'b1, t, 6'b0, 4'(src), 4'(dst)};
    endfunction

    function automatic logic [16:0] data_flit(input logic [1:0] t);
        return {1'b1, t, 14'($urandom)};
    endfunction

    function automatic bit starts(input logic [16:0] f);
        return f[16] == 1'b1 && (f[15:14] == 2'b01 || f[15:14] == 2'b11);
    endfunction

    function automatic bit conts(input logic [16:0] f);
        return f[16] == 1'b1 && (f[15:14] == 2'b00 || f[15:14] == 2'b10);
    endfunction

    task automatic push_pkt(input int k, input int nbody);
        if (nbody < 0) begin
            q[k].push_back(hdr_flit(SINGLE, k, $urandom_range(15)));
        end else begin
            q[k].push_back(hdr_flit(HEAD, k, $urandom_range(15)));
            repeat (nbody) q[k].push_back(data_flit(BODY));
            q[k].push_back(data_flit(TAIL));
        end
    endtask

    task automatic flush();
        for (int k = 0; k < 5; k++) q[k].delete();
    endtask

    // Present queue heads, sample mid-cycle, predict from the model, then advance the model.
    task automatic cycle();
        logic [16:0] h [5];
        int          p;
        bit          set_err, go_stall;
        logic [4:0]  epop;
        p = -1;
        set_err = 0;
        go_stall = 0;
        for (int k = 0; k < 5; k++) begin
            h[k] = (q[k].size() > 0 && !hold[k]) ? q[k][0] : 17'h0;
            in_flit[k*17 +: 17] = h[k];
        end
        @(negedge clk);
        if (!rst && !full) begin
            if (m_mode == 0) begin
                for (int i = 0; i < 5; i++)
                    if (p < 0 && starts(h[(m_ptr + i) % 5])) p = (m_ptr + i) % 5;
                for (int k = 0; k < 5; k++)
                    if (conts(h[k])) set_err = 1;
            end else if (m_mode == 1) begin
                if (conts(h[m_owner])) p = m_owner;
                else if (starts(h[m_owner])) begin set_err = 1; go_stall = 1; end
            end
        end
        epop  = (p >= 0) ? 5'(1 << p) : 5'd0;
        exp_v = {epop, m_out, (m_mode != 0) ? 5'(1 << m_owner) : 5'd0, m_mode != 0, m_err};
        obs_v = {pop, out_flit, grant, locked, err};
        if (rst) begin
            m_mode = 0; m_ptr = 0; m_err = 0; m_out = '0;
        end else begin
            if (set_err) m_err = 1'b1;
            if (go_stall) m_mode = 2;
            m_out = (p >= 0) ? h[p] : 17'h0;
            if (p >= 0) begin
                void'(q[p].pop_front());
                if (m_mode == 0 && h[p][15:14] == 2'b11) m_ptr = (p + 1) % 5;
                else if (m_mode == 0) begin m_mode = 1; m_owner = p; end
                else if (h[p][15:14] == 2'b10) begin m_mode = 0; m_ptr = (m_owner + 1) % 5; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        flush();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        q[0].push_back(hdr_flit(SINGLE, 0, 1));
        cycle();
        if (obs_v[28:24] !== 5'b0) begin miscompares++; $display("FAIL reset_pop got %b want 00000", obs_v[28:24]); end
        vectors++;
        cycle();
        if (obs_v !== 29'h0) begin miscompares++; $display("FAIL reset_vals got %h want 0", obs_v); end
        vectors++;
        rst = 1'b0;
        flush();
    endtask

    task automatic test_single();
        q[4].push_back(17'h1C035);
        cycle();
        if (obs_v[28:24] !== 5'b10000) begin miscompares++; $display("FAIL single_pop got %b want 10000", obs_v[28:24]); end
        vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL single_model got %h want %h", obs_v, exp_v); end
        vectors++;
        cycle();
        if (obs_v[23:7] !== 17'h1C035) begin miscompares++; $display("FAIL single_out got %h want 1c035", obs_v[23:7]); end
        vectors++;
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL single_model2 got %h want %h", obs_v, exp_v); end
        vectors++;
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 3; c++) begin push_pkt(0, -1); push_pkt(2, -1); push_pkt(4, -1); end
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL rr_model c%0d got %h want %h", c, obs_v, exp_v); end
            vectors++;
            if (c < 9 && obs_v[28:24] !== 5'(1 << (2 * (c % 3)))) begin
                miscompares++; $display("FAIL rr_order c%0d got %b want %b", c, obs_v[28:24], 5'(1 << (2 * (c % 3))));
            end
            if (c < 9) vectors++;
        end
    endtask

    task automatic test_wormhole();
        int exp_src [6] = '{1, 1, 1, 1, 3, 3};
        push_pkt(1, 2);
        push_pkt(3, 0);
        for (int c = 0; c < 7; c++) begin
            cycle();
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL worm_model c%0d got %h want %h", c, obs_v, exp_v); end
            vectors++;
            if (c < 6 && obs_v[28:24] !== 5'(1 << exp_src[c])) begin
                miscompares++; $display("FAIL worm_order c%0d got %b want %b", c, obs_v[28:24], 5'(1 << exp_src[c]));
            end
            if (c < 6) vectors++;
            if (c >= 1 && c <= 3 && obs_v[1] !== 1'b1) begin miscompares++; $display("FAIL worm_locked c%0d got %b want 1", c, obs_v[1]); end
            if (c >= 1 && c <= 3) vectors++;
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] sent [$];
        logic [16:0] got [$];
        push_pkt(0, 3);
        sent = q[0];
        for (int c = 0; c < 9; c++) begin
            full = (c >= 2 && c < 5);
            cycle();
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL bp_model c%0d got %h want %h", c, obs_v, exp_v); end
            vectors++;
            if (full && obs_v[28:24] !== 5'b0) begin miscompares++; $display("FAIL bp_pop c%0d got %b want 00000", c, obs_v[28:24]); end
            if (full) vectors++;
            if (c >= 3 && c <= 5 && obs_v[23] !== 1'b0) begin miscompares++; $display("FAIL bp_idle c%0d got %b want 0", c, obs_v[23]); end
            if (c >= 3 && c <= 5) vectors++;
            if (obs_v[23] === 1'b1) got.push_back(obs_v[23:7]);
        end
        full = 1'b0;
        if (got != sent) begin miscompares++; $display("FAIL bp_stream got %0d flits want %0d in order", got.size(), sent.size()); end
        vectors++;
    endtask

    task automatic test_protocol();
        apply_reset();
        q[2].push_back(data_flit(BODY));
        push_pkt(0, -1);
        push_pkt(4, -1);
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL perr_idle_model c%0d got %h want %h", c, obs_v, exp_v); end
            vectors++;
            if (obs_v[26] !== 1'b0) begin miscompares++; $display("FAIL perr_body_pop c%0d got %b want 0", c, obs_v[26]); end
            vectors++;
            if (c >= 1 && obs_v[0] !== 1'b1) begin miscompares++; $display("FAIL perr_idle_err c%0d got %b want 1", c, obs_v[0]); end
            if (c >= 1) vectors++;
        end
        apply_reset();
        q[1].push_back(hdr_flit(HEAD, 1, 7));
        q[1].push_back(hdr_flit(HEAD, 1, 8));
        push_pkt(3, -1);
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL perr_lock_model c%0d got %h want %h", c, obs_v, exp_v); end
            vectors++;
            if (c >= 1 && obs_v[28:24] !== 5'b0) begin miscompares++; $display("FAIL perr_stall_pop c%0d got %b want 00000", c, obs_v[28:24]); end
            if (c >= 1) vectors++;
            if (c >= 2 && obs_v[0] !== 1'b1) begin miscompares++; $display("FAIL perr_lock_err c%0d got %b want 1", c, obs_v[0]); end
            if (c >= 2) vectors++;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        push_pkt(2, 2);
        for (int c = 0; c < 2; c++) begin
            cycle();
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL rmid_model c%0d got %h want %h", c, obs_v, exp_v); end
            vectors++;
        end
        rst = 1'b1;
        flush();
        push_pkt(0, 0);
        push_pkt(3, 0);
        cycle();
        if (obs_v[28:24] !== 5'b0) begin miscompares++; $display("FAIL rmid_rst_pop got %b want 00000", obs_v[28:24]); end
        vectors++;
        rst = 1'b0;
        cycle();
        if (obs_v[23:0] !== 24'h0) begin miscompares++; $display("FAIL rmid_clear got %h want 0", obs_v[23:0]); end
        vectors++;
        if (obs_v[28:24] !== 5'b00001) begin miscompares++; $display("FAIL rmid_first got %b want 00001", obs_v[28:24]); end
        vectors++;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL rmid_drain c%0d got %h want %h", c, obs_v, exp_v); end
            vectors++;
        end
    endtask

    task automatic test_random();
        int guard = 0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 5; k++)
                if ($urandom_range(2) == 0 && q[k].size() < 8) push_pkt(k, int'($urandom_range(3)) - 1);
            hold = 5'($urandom & $urandom);
            full = ($urandom_range(4) == 0);
            cycle();
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL rand_model c%0d got %h want %h", c, obs_v, exp_v); end
            vectors++;
        end
        hold = '0;
        full = 1'b0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() + q[4].size() > 0 || m_mode != 0) && guard < 200) begin
            cycle();
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL rand_drain g%0d got %h want %h", guard, obs_v, exp_v); end
            vectors++;
            guard++;
        end
        cycle();
        if (obs_v !== exp_v) begin miscompares++; $display("FAIL rand_last got %h want %h", obs_v, exp_v); end
        vectors++;
        if (guard >= 200) begin miscompares++; $display("FAIL rand_timeout got %0d cycles want under 200", guard); end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wormhole();
        test_backpressure();
        test_protocol();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
